uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 115 +++++++++++
 tb/tb_uart_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo -- synchronous FIFO buffer shared by UART Rx/Tx paths and host.
//
// First-word fall-through: data_o always shows the head entry (valid while
// empty_o=0). Occupancy is tracked with ADDR_W+1 bit pointers whose MSB is a
// wrap bit, so full and empty are distinguished without an extra counter.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_ni         synchronous active-low reset (pointers and sticky flags)
//   clear_i        synchronous flush, active-high; push/pop ignored that cycle
//   push_i/data_i  write request and write data
//   pop_i          read request
//   data_o         head entry (combinational from storage)
//   empty_o        no entries stored
//   full_o         2**ADDR_W entries stored
//   almost_full_o  count_o >= AFULL_THRESH
//   count_o        occupancy 0..2**ADDR_W
//   overflow_o     sticky: push rejected because full
//   underflow_o    sticky: pop rejected because empty
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AFULL_CNT = AFULL_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Storage is deliberately not reset; only the pointers define validity.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic empty, full;
  logic push_acc, pop_acc;
  logic mem_we;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // A pop frees the slot the same edge, so a push into a full FIFO is
  // accepted only when it is paired with an accepted pop.
  assign pop_acc  = pop_i && !empty;
  assign push_acc = push_i && (!full || pop_acc);

  // Writes are suppressed while in reset or flushing so the request is
  // truly ignored, not just uncounted.
  assign mem_we = rst_ni && !clear_i && push_acc;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_i && !push_acc) overflow_d  = 1'b1;
      if (pop_i && empty)      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
  end

  assign data_o        = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign empty_o       = empty;
  assign full_o        = full;
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign almost_full_o = (count_o >= AFULL_CNT);
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_uart_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo -- directed self-checking bench for uart_fifo (defaults:
// 8-bit data, depth 16, almost-full at 12). Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, before new inputs.
// ---------------------------------------------------------------------------
module tb_uart_fifo;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       push;
  logic [7:0] din;
  logic       pop;
  logic [7:0] dout;
  logic       empty, full, afull, ovf, unf;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  uart_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .push_i(push),
    .data_i(din), .pop_i(pop), .data_o(dout), .empty_o(empty),
    .full_o(full), .almost_full_o(afull), .count_o(count),
    .overflow_o(ovf), .underflow_o(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [7:0] d, input logic q);
    push = p;
    din  = d;
    pop  = q;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    tick();
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (afull !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", afull); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b%b exp=00", ovf, unf); end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
      total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      total++; if (afull !== ((i + 1) >= 12)) begin bad++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, afull, ((i + 1) >= 12)); end
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL fill_head i=%0d got=%h exp=00", i, dout); end
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    for (int i = 0; i < 16; i++) begin
      total++; if (dout !== 8'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, dout, 8'(i)); end
      drive(1'b0, 8'h00, 1'b1);
      tick();
      total++; if (count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 15 - i); end
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL drain_empty got e=%b f=%b exp e=1 f=0", empty, full); end
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL drain_unf got=%b exp=0", unf); end
    $display("test_fill_drain done");
  endtask

  task automatic test_overflow();
    fill16();
    drive(1'b1, 8'hAA, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL ovf_head got=%h exp=00", dout); end
    for (int i = 0; i < 16; i++) begin
      total++; if (dout !== 8'(i)) begin bad++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, dout, 8'(i)); end
      drive(1'b0, 8'h00, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    do_clear();
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
    $display("test_overflow done");
  endtask

  task automatic test_underflow_simul();
    drive(1'b1, 8'h55, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total++; if (count !== 5'd1) begin bad++; $display("FAIL unf_count got=%0d exp=1", count); end
    total++; if (unf !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", unf); end
    total++; if (dout !== 8'h55) begin bad++; $display("FAIL unf_data got=%h exp=55", dout); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL unf_notempty got=%b exp=0", empty); end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL unf_popped got=%b exp=1", empty); end
    do_clear();
    total++; if (unf !== 1'b0) begin bad++; $display("FAIL unf_cleared got=%b exp=0", unf); end
    $display("test_underflow_simul done");
  endtask

  task automatic test_full_simul();
    fill16();
    drive(1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fsim_count got=%0d exp=16", count); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fsim_ovf got=%b exp=0", ovf); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fsim_full got=%b exp=1", full); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'(i + 1) : 8'h77;
      total++; if (dout !== exp_d) begin bad++; $display("FAIL fsim_drain i=%0d got=%h exp=%h", i, dout, exp_d); end
      drive(1'b0, 8'h00, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fsim_empty got=%b exp=1", empty); end
    $display("test_full_simul done");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      total++; if (dout !== 8'(k)) begin bad++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, dout, 8'(k)); end
      drive(1'b1, 8'(k + 3), 1'b1);
      tick();
      total++; if (count !== 5'd3) begin bad++; $display("FAIL wrap_count k=%0d got=%0d exp=3", k, count); end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (dout !== 8'(40 + i)) begin bad++; $display("FAIL wrap_tail i=%0d got=%h exp=%h", i, dout, 8'(40 + i)); end
      drive(1'b0, 8'h00, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    $display("test_wrap done");
  endtask

  // Builds count=9 with underflow set, then flushes via clear (use_reset=0)
  // or reset (use_reset=1) while a push is requested.
  task automatic test_flush(input logic use_reset);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (count !== 5'd9 || unf !== 1'b1) begin bad++; $display("FAIL flush%0d_pre got cnt=%0d unf=%b exp cnt=9 unf=1", use_reset, count, unf); end
    drive(1'b1, 8'hEE, 1'b0);
    if (use_reset) rst_n = 1'b0; else clear = 1'b1;
    tick();
    rst_n = 1'b1;
    clear = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL flush%0d_count got=%0d exp=0", use_reset, count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush%0d_empty got=%b exp=1", use_reset, empty); end
    total++; if (ovf !== 1'b0 || unf !== 1'b0 || full !== 1'b0 || afull !== 1'b0) begin bad++; $display("FAIL flush%0d_flags got o=%b u=%b f=%b a=%b exp all 0", use_reset, ovf, unf, full, afull); end
    drive(1'b1, 8'h3C, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total++; if (dout !== 8'h3C || count !== 5'd1) begin bad++; $display("FAIL flush%0d_after got d=%h cnt=%0d exp d=3c cnt=1", use_reset, dout, count); end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    $display("test_flush use_reset=%0d done", use_reset);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_full_simul();
    test_wrap();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
